// File: rtl/sw_pkg.sv
// Shared constants for the switch input conditioning stage.
// Switch pins are active-low, so the idle level is 1.
package sw_pkg;

    localparam logic SW_RELEASED = 1'b1;
    localparam logic SW_PRESSED  = 1'b0;

    // 10 ms at 50 MHz on the board; short window for simulation.
    localparam int unsigned DEBOUNCE_CYCLES_BOARD = 500000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchroniser, stability counter,
// debounced level register and registered press/release pulses.
module sw_debounce_ch
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
    parameter int unsigned CNT_W           = 19
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic db_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             db_q,      db_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

    // Any sample agreeing with the current level restarts the window;
    // the terminal count always commits, so the counter never wraps.
    always_comb begin
        db_d      = db_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_TERM) begin
            db_d      = s2_q;
            cnt_d     = '0;
            press_d   = (s2_q == SW_PRESSED);
            release_d = (s2_q == SW_RELEASED);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q      <= SW_RELEASED;
            s2_q      <= SW_RELEASED;
            db_q      <= SW_RELEASED;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= sw_i;
            s2_q      <= s1_q;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign db_o      = db_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces N_SW active-low push switches; outputs a clean level plus
// one-cycle press/release pulses per channel.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int unsigned N_SW            = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
    parameter int unsigned CNT_W           = 19
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N_SW-1:0] SW_IN,
    output logic [N_SW-1:0] SW_DB,
    output logic [N_SW-1:0] PRESS,
    output logic [N_SW-1:0] RELEASE
);

    genvar g;
    for (g = 0; g < N_SW; g++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk_i    (CLK),
            .rst_ni   (RST_N),
            .sw_i     (SW_IN[g]),
            .db_o     (SW_DB[g]),
            .press_o  (PRESS[g]),
            .release_o(RELEASE[g])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with a 4-cycle debounce window.
module tb_sw_debounce;

    logic       CLK;
    logic       RST_N;
    logic [2:0] SW_IN;
    logic [2:0] SW_DB;
    logic [2:0] PRESS;
    logic [2:0] RELEASE;

    int unsigned checks = 0;
    int unsigned fails  = 0;
    logic [2:0]  exp_db;

    sw_debounce #(
        .N_SW           (3),
        .DEBOUNCE_CYCLES(sw_pkg::DEBOUNCE_CYCLES_SIM),
        .CNT_W          (3)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .SW_IN  (SW_IN),
        .SW_DB  (SW_DB),
        .PRESS  (PRESS),
        .RELEASE(RELEASE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_db"}, SW_DB, exp_db);
        chk({tag, "_press"}, PRESS, 3'b000);
        chk({tag, "_rel"}, RELEASE, 3'b000);
    endtask

    // Drive a new input; expect nothing for 5 edges, the new level and
    // pulses on edge 6, and the pulses gone on edge 7.
    task automatic expect_change(input string tag, input logic [2:0] new_in,
                                 input logic [2:0] new_db, input logic [2:0] prs,
                                 input logic [2:0] rel);
        SW_IN = new_in;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_quiet({tag, "_wait"});
        end
        tick();
        chk({tag, "_db6"}, SW_DB, new_db);
        chk({tag, "_press6"}, PRESS, prs);
        chk({tag, "_rel6"}, RELEASE, rel);
        exp_db = new_db;
        tick();
        chk_quiet({tag, "_after"});
    endtask

    initial begin
        RST_N  = 1'b0;
        SW_IN  = 3'b000;
        exp_db = 3'b111;

        // Reset with all switches held
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_quiet("reset");
        end
        RST_N = 1'b1;
        expect_change("held_at_reset", 3'b000, 3'b000, 3'b111, 3'b000);
        expect_change("release_all", 3'b111, 3'b111, 3'b000, 3'b111);

        // Clean press / release on channel 0
        expect_change("press0", 3'b110, 3'b110, 3'b001, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("hold0");
        end
        expect_change("release0", 3'b111, 3'b111, 3'b000, 3'b001);

        // Glitch on channel 1 shorter than the window
        SW_IN = 3'b101;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("glitch_low");
        end
        SW_IN = 3'b111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_quiet("glitch_high");
        end
        // Counter must have restarted: a real press still needs the full latency
        expect_change("post_glitch1", 3'b101, 3'b101, 3'b010, 3'b000);
        expect_change("post_glitch1_rel", 3'b111, 3'b111, 3'b000, 3'b010);

        // Bounce on channel 2, then settle low
        for (int i = 0; i < 12; i++) begin
            SW_IN = ((i / 2) % 2 == 0) ? 3'b011 : 3'b111;
            tick();
            chk_quiet("bounce");
        end
        expect_change("bounce_settle", 3'b011, 3'b011, 3'b100, 3'b000);
        expect_change("bounce_rel", 3'b111, 3'b111, 3'b000, 3'b100);

        // Simultaneous press on ch0 and release on ch1
        expect_change("to_101", 3'b101, 3'b101, 3'b010, 3'b000);
        expect_change("simul", 3'b110, 3'b110, 3'b001, 3'b010);
        expect_change("simul_rel", 3'b111, 3'b111, 3'b000, 3'b001);

        // Reset in the middle of a count on channel 0
        SW_IN = 3'b110;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_quiet("midcount");
        end
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("midcount_rst");
        end
        RST_N = 1'b1;
        expect_change("after_rst", 3'b110, 3'b110, 3'b001, 3'b000);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
